// File: rtl/lcd_scene_scheduler.sv
// Scene sequencer for the 16x2 LCD figure driver: picks the pet face and stat icon
// for each frame, rotates icons, and lets pending game events preempt the rotation.
module lcd_scene_scheduler #(
  parameter int LVL_W        = 3,
  parameter int LOW_TH       = 2,
  parameter int HIGH_TH      = 5,
  parameter int DWELL_FRAMES = 4,
  parameter int ALERT_FRAMES = 8,
  parameter int TIMEOUT      = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [LVL_W-1:0] lvl_health,
  input  logic [LVL_W-1:0] lvl_food,
  input  logic [LVL_W-1:0] lvl_energy,
  input  logic [LVL_W-1:0] lvl_fun,
  input  logic [3:0]       ev_req,
  input  logic             frame_done,
  output logic [3:0]       select_figures,
  output logic             frame_start,
  output logic [3:0]       ev_ack,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_MAX = (DWELL_FRAMES > ALERT_FRAMES) ? DWELL_FRAMES : ALERT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [LVL_W-1:0] LOW_L       = LVL_W'(LOW_TH);
  localparam logic [LVL_W-1:0] HIGH_L      = LVL_W'(HIGH_TH);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_FRAMES - 1);
  localparam logic [CNT_W-1:0] ALERT_LAST  = CNT_W'(ALERT_FRAMES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] FIG1_SAD     = 2'b00;
  localparam logic [1:0] FIG1_HAPPY   = 2'b01;
  localparam logic [1:0] FIG1_NEUTRAL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_COUNT} state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [1:0]       rot_idx;
  logic [CNT_W-1:0] frame_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             cur_alert;
  logic [1:0]       cur_bit;

  logic       any_low;
  logic       all_high;
  logic       alert_hit;
  logic [1:0] fig1_next;
  logic [1:0] scene_bit;
  logic [1:0] fig2_next;
  logic [3:0] clr_mask;

  // Scenes are named by their event bit position: 3 health, 2 food, 1 energy, 0 fun.
  function automatic logic [1:0] icon_code(input logic [1:0] bit_pos);
    case (bit_pos)
      2'd3:    icon_code = 2'b00;
      2'd2:    icon_code = 2'b10;
      2'd1:    icon_code = 2'b01;
      default: icon_code = 2'b11;
    endcase
  endfunction

  always_comb begin
    any_low  = (lvl_health < LOW_L) || (lvl_food < LOW_L) ||
               (lvl_energy < LOW_L) || (lvl_fun < LOW_L);
    all_high = (lvl_health >= HIGH_L) && (lvl_food >= HIGH_L) &&
               (lvl_energy >= HIGH_L) && (lvl_fun >= HIGH_L);
    fig1_next = FIG1_NEUTRAL;
    if (any_low)
      fig1_next = FIG1_SAD;
    else if (all_high)
      fig1_next = FIG1_HAPPY;

    alert_hit = |pending;
    scene_bit = 2'd3 - rot_idx;
    if (pending[3])
      scene_bit = 2'd3;
    else if (pending[2])
      scene_bit = 2'd2;
    else if (pending[1])
      scene_bit = 2'd1;
    else if (pending[0])
      scene_bit = 2'd0;
    fig2_next = icon_code(scene_bit);

    clr_mask = 4'b0000;
    if (state == S_COUNT && cur_alert && frame_cnt == ALERT_LAST)
      clr_mask = 4'b0001 << cur_bit;
  end

  // A new request on a bit being cleared this cycle wins, so that event is served again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      select_figures <= 4'b1000;
      frame_start    <= 1'b0;
      ev_ack         <= 4'b0000;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      pending        <= 4'b0000;
      rot_idx        <= 2'd0;
      frame_cnt      <= '0;
      tmo_cnt        <= '0;
      cur_alert      <= 1'b0;
      cur_bit        <= 2'd3;
    end else begin
      frame_start <= 1'b0;
      ev_ack      <= 4'b0000;
      pending     <= (pending & ~clr_mask) | ev_req;
      case (state)
        S_IDLE: begin
          if (enable_i)
            state <= S_LOAD;
        end
        S_LOAD: begin
          select_figures <= {fig1_next, fig2_next};
          cur_alert      <= alert_hit;
          cur_bit        <= scene_bit;
          if ({alert_hit, scene_bit} != {cur_alert, cur_bit})
            frame_cnt <= '0;
          frame_start <= 1'b1;
          busy        <= 1'b1;
          tmo_cnt     <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (frame_done) begin
            busy  <= 1'b0;
            state <= S_COUNT;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_COUNT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_COUNT: begin
          if (cur_alert) begin
            if (frame_cnt == ALERT_LAST) begin
              frame_cnt <= '0;
              ev_ack    <= clr_mask & ~ev_req;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end else begin
            if (frame_cnt == DWELL_LAST) begin
              frame_cnt <= '0;
              rot_idx   <= rot_idx + 2'd1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          state <= enable_i ? S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scene_scheduler.sv
// Scoreboard bench for lcd_scene_scheduler: a frame-level model predicts each scene
// and each event acknowledge; a monitor compares them as the DUT presents them.
module tb_lcd_scene_scheduler;

  localparam int ALERT_FRAMES = 8;
  localparam int DWELL_FRAMES = 4;
  localparam int TIMEOUT      = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_i;
  logic [2:0] lvl_health, lvl_food, lvl_energy, lvl_fun;
  logic [3:0] ev_req;
  logic       frame_done;
  logic [3:0] select_figures;
  logic       frame_start;
  logic [3:0] ev_ack;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_sel_q[$];
  logic [3:0] exp_ack_q[$];

  // Reference model state, in stat terms: 0 health, 1 food, 2 energy, 3 fun.
  logic [3:0] m_pending;
  int         m_rot;
  int         m_cnt;
  int         m_scene;
  bit         m_cur_alert;
  int         m_cur_stat;
  int         fig2_code[4] = '{0, 2, 1, 3};

  lcd_scene_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .lvl_health     (lvl_health),
    .lvl_food       (lvl_food),
    .lvl_energy     (lvl_energy),
    .lvl_fun        (lvl_fun),
    .ev_req         (ev_req),
    .frame_done     (frame_done),
    .select_figures (select_figures),
    .frame_start    (frame_start),
    .ev_ack         (ev_ack),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_pending   = 4'b0000;
    m_rot       = 0;
    m_cnt       = 0;
    m_scene     = 0;
    m_cur_alert = 0;
    m_cur_stat  = 0;
  endtask

  task automatic setLevels(input int h, input int f, input int e, input int u);
    lvl_health = 3'(h);
    lvl_food   = 3'(f);
    lvl_energy = 3'(e);
    lvl_fun    = 3'(u);
  endtask

  task automatic modelPredict();
    int lv[4];
    int nlow, nhigh, fig1, stat, scene;
    bit found;
    lv[0] = int'(lvl_health);
    lv[1] = int'(lvl_food);
    lv[2] = int'(lvl_energy);
    lv[3] = int'(lvl_fun);
    nlow = 0;
    nhigh = 0;
    foreach (lv[i]) begin
      if (lv[i] < 2) nlow++;
      if (lv[i] >= 5) nhigh++;
    end
    fig1 = (nlow > 0) ? 0 : ((nhigh == 4) ? 1 : 2);
    found = 0;
    stat = m_rot;
    for (int s = 0; s < 4; s++)
      if (!found && m_pending[3-s]) begin
        found = 1;
        stat = s;
      end
    scene = found ? 4 + stat : stat;
    if (scene != m_scene) m_cnt = 0;
    m_scene     = scene;
    m_cur_alert = found;
    m_cur_stat  = stat;
    exp_sel_q.push_back(4'((fig1 << 2) | fig2_code[stat]));
  endtask

  task automatic modelComplete(input logic [3:0] req_now);
    logic [3:0] mask;
    m_cnt++;
    if (m_cur_alert) begin
      if (m_cnt == ALERT_FRAMES) begin
        m_cnt = 0;
        mask = 4'(1 << (3 - m_cur_stat));
        if ((req_now & mask) == 4'b0000) begin
          m_pending = m_pending & ~mask;
          exp_ack_q.push_back(mask);
        end
      end
    end else if (m_cnt == DWELL_FRAMES) begin
      m_cnt = 0;
      m_rot = (m_rot + 1) % 4;
    end
    m_pending = m_pending | req_now;
  endtask

  // One frame: predict, enable, act as the LCD driver; delay 0 means never answer.
  task automatic applyStimulus(input int delay, input logic [3:0] ev_mid, input logic [3:0] ev_cnt,
                               input bit collide, input bit en_after);
    bit got;
    int cyc;
    logic [3:0] evc;
    modelPredict();
    enable_i = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_start) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checkOutput("frame_start_wait", 32'(got), 32'd1);
      return;
    end
    @(negedge clk);
    ev_req = ev_mid;
    m_pending = m_pending | ev_mid;
    if (!en_after) enable_i = 1'b0;
    @(negedge clk);
    ev_req = 4'b0000;
    cyc = 2;
    if (delay == 0) begin
      while (busy && cyc < TIMEOUT + 50) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("timeout_cycles", 32'(cyc), 32'(TIMEOUT));
      checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
    end else begin
      repeat (delay - 2) @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      checkOutput("busy_after_done", 32'(busy), 32'd0);
    end
    evc = ev_cnt;
    if (collide && m_cur_alert && m_cnt == ALERT_FRAMES - 1)
      evc = evc | 4'(1 << (3 - m_cur_stat));
    ev_req = evc;
    modelComplete(evc);
    @(negedge clk);
    ev_req = 4'b0000;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (frame_start) begin
        if (exp_sel_q.size() == 0) begin
          checkOutput("unexpected_frame_start", 32'(frame_start), 32'd0);
        end else begin
          checkOutput("select_figures", 32'(select_figures), 32'(exp_sel_q.pop_front()));
          checkOutput("busy_at_start", 32'(busy), 32'd1);
        end
      end
      if (ev_ack != 4'b0000) begin
        if (exp_ack_q.size() == 0)
          checkOutput("unexpected_ev_ack", 32'(ev_ack), 32'd0);
        else
          checkOutput("ev_ack", 32'(ev_ack), 32'(exp_ack_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    reset = 1'b1;
    enable_i = 1'b0;
    ev_req = 4'b0000;
    frame_done = 1'b0;
    setLevels(7, 7, 7, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_select", 32'(select_figures), 32'h8);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ev_ack", 32'(ev_ack), 32'd0);
    checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
    modelReset();

    $display("[TB] full rotation, all stats full");
    for (int i = 0; i < 20; i++) applyStimulus(10, 4'b0000, 4'b0000, 0, 1);

    $display("[TB] face selection from levels");
    setLevels(7, 1, 7, 7);
    for (int i = 0; i < 3; i++) applyStimulus(10, 4'b0000, 4'b0000, 0, 1);
    setLevels(3, 3, 3, 3);
    for (int i = 0; i < 3; i++) applyStimulus(8, 4'b0000, 4'b0000, 0, 1);
    setLevels(5, 5, 5, 4);
    applyStimulus(6, 4'b0000, 4'b0000, 0, 1);
    setLevels(5, 5, 5, 5);
    applyStimulus(6, 4'b0000, 4'b0000, 0, 1);

    $display("[TB] energy alert mid-rotation");
    applyStimulus(10, 4'b0010, 4'b0000, 0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(10, 4'b0000, 4'b0000, 0, 1);

    $display("[TB] fun alert preempted by health");
    applyStimulus(9, 4'b0001, 4'b0000, 0, 1);
    applyStimulus(9, 4'b0000, 4'b0000, 0, 1);
    applyStimulus(9, 4'b1000, 4'b0000, 0, 1);
    for (int i = 0; i < 18; i++) applyStimulus(9, 4'b0000, 4'b0000, 0, 1);

    $display("[TB] request colliding with its own clear");
    applyStimulus(5, 4'b0100, 4'b0000, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(5, 4'b0000, 4'b0000, 1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(5, 4'b0000, 4'b0000, 0, 1);

    $display("[TB] enable low parks in IDLE");
    applyStimulus(7, 4'b0000, 4'b0000, 0, 0);
    repeat (4) @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] frame timeout");
    applyStimulus(0, 4'b0000, 4'b0000, 0, 1);
    applyStimulus(10, 4'b0000, 4'b0000, 0, 1);
    checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0)
        setLevels($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else if ($urandom_range(0, 5) == 0)
        setLevels(7, 6, 5, 5);
      applyStimulus($urandom_range(3, 12),
                    ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                    $urandom_range(0, 5) == 0, 1);
    end

    $display("[TB] reset during WAIT");
    setLevels(7, 7, 7, 7);
    applyStimulus(10, 4'b1010, 4'b0000, 0, 1);
    modelPredict();
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_start) begin
        got = 1;
        break;
      end
    end
    checkOutput("frame_start_before_reset", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ev_req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    ev_req = 4'b0000;
    enable_i = 1'b0;
    checkOutput("midreset_select", 32'(select_figures), 32'h8);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_ev_ack", 32'(ev_ack), 32'd0);
    checkOutput("midreset_frame_start", 32'(frame_start), 32'd0);
    checkOutput("midreset_timeout_err", 32'(timeout_err), 32'd0);
    modelReset();
    for (int i = 0; i < 5; i++) applyStimulus(10, 4'b0000, 4'b0000, 0, 1);
    applyStimulus(10, 4'b0000, 4'b0000, 0, 0);

    repeat (10) @(negedge clk);
    checkOutput("sel_queue_empty", 32'(exp_sel_q.size()), 32'd0);
    checkOutput("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
